// File: rtl/peripheral_apb4_pkg.sv
// Shared APB4 completer definitions: bus widths, PPROT bit positions and
// the transfer-phase state encoding used by the wait-state sequencer.
package peripheral_apb4_pkg;

  localparam int unsigned HADDR_SIZE = 32;
  localparam int unsigned HDATA_SIZE = 32;
  localparam int unsigned PSTRB_SIZE = HDATA_SIZE / 8;

  localparam int unsigned PPROT_PRIV  = 0;
  localparam int unsigned PPROT_NSEC  = 1;
  localparam int unsigned PPROT_INSTR = 2;

  // Wide enough for the largest supported wait-state count (15)
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/peripheral_apb4_wait_counter.sv
// Transfer-phase sequencer: tracks setup/access and counts wait states,
// raising o_ready in the access cycle that is allowed to complete.
module peripheral_apb4_wait_counter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_psel,
  input  logic i_penable,
  output logic o_ready
);
  import peripheral_apb4_pkg::*;

  apb_state_e            r_state;
  apb_state_e            w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        // PENABLE high while idle is a protocol violation and is ignored
        if (i_psel && !i_penable) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!i_psel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
        end else if (i_penable) begin
          o_ready     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/peripheral_apb4_slave_regfile.sv
// APB4 completer with a byte-strobed register bank; the top index is a
// read-only counter of error-free transfers.
module peripheral_apb4_slave_regfile #(
  parameter int unsigned HADDR_SIZE  = peripheral_apb4_pkg::HADDR_SIZE,
  parameter int unsigned HDATA_SIZE  = peripheral_apb4_pkg::HDATA_SIZE,
  parameter int unsigned REG_COUNT   = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [HADDR_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [HDATA_SIZE-1:0]   PWDATA,
  input  logic [HDATA_SIZE/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [HDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  import peripheral_apb4_pkg::*;

  localparam int unsigned IDX_W  = $clog2(REG_COUNT);
  localparam int unsigned NBYTES = HDATA_SIZE / 8;

  logic                  w_ready;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_is_cnt;
  logic                  w_err;
  logic                  w_wr_en;
  logic                  w_done_ok;
  logic [HDATA_SIZE-1:0] w_rd_val;
  logic                  w_unused;

  logic [HDATA_SIZE-1:0] r_regs [REG_COUNT-1];
  logic [HDATA_SIZE-1:0] r_xfer_cnt;

  peripheral_apb4_wait_counter #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait (
    .i_clk     (PCLK),
    .i_rst     (PRESET),
    .i_psel    (PSEL),
    .i_penable (PENABLE),
    .o_ready   (w_ready)
  );

  assign w_idx    = PADDR[2 +: IDX_W];
  assign w_oor    = |PADDR[HADDR_SIZE-1:IDX_W+2];
  assign w_is_cnt = (w_idx == IDX_W'(REG_COUNT - 1));

  assign w_err = w_oor
               | (PWRITE  & (w_is_cnt | ~PPROT[PPROT_PRIV]))
               | (~PWRITE & (|PSTRB));

  assign w_done_ok = w_ready & ~w_err;
  assign w_wr_en   = w_done_ok & PWRITE;

  // Byte-lane alignment and the non-privilege PPROT bits play no part in decode
  assign w_unused = &{1'b0, PADDR[1:0], PPROT[PPROT_NSEC], PPROT[PPROT_INSTR]};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int unsigned i = 0; i < REG_COUNT - 1; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      for (int unsigned i = 0; i < REG_COUNT - 1; i++) begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
          if (w_idx == IDX_W'(i) && PSTRB[b]) begin
            r_regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_xfer_cnt <= '0;
    end else if (w_done_ok) begin
      r_xfer_cnt <= r_xfer_cnt + HDATA_SIZE'(1);
    end
  end

  always_comb begin
    w_rd_val = r_xfer_cnt;
    for (int unsigned i = 0; i < REG_COUNT - 1; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_rd_val = r_regs[i];
      end
    end
  end

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready & w_err;
  assign PRDATA  = (w_done_ok & ~PWRITE) ? w_rd_val : '0;

endmodule

// File: tb/tb_peripheral_apb4_slave_regfile.sv
// Bench for the APB4 register-file completer: three instances with
// different wait-state counts, checked against a behavioural model.
module tb_peripheral_apb4_slave_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mregs [3][8];
  logic [31:0] mcnt  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WSG = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    peripheral_apb4_slave_regfile #(
      .HADDR_SIZE  (32),
      .HDATA_SIZE  (32),
      .REG_COUNT   (8),
      .WAIT_STATES (WSG)
    ) u_dut (
      .PCLK    (clk),
      .PRESET  (rst),
      .PSEL    (psel[g]),
      .PENABLE (penable),
      .PADDR   (paddr),
      .PWRITE  (pwrite),
      .PWDATA  (pwdata),
      .PSTRB   (pstrb),
      .PPROT   (pprot),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = '0;
      for (int i = 0; i < 8; i++) mregs[k][i] = '0;
    end
  endfunction

  // Reference behaviour: 8 words at byte addresses 0..31, word 7 is the counter
  function automatic void model_xfer(input int k, input bit wr, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] s,
                                     input logic [2:0] p, output bit err,
                                     output logic [31:0] rd);
    int idx;
    idx = int'(a / 4) % 8;
    err = (a >= 32) || (wr && (idx == 7 || !p[0])) || (!wr && s != 0);
    rd  = '0;
    if (!err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mregs[k][idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        rd = (idx == 7) ? mcnt[k] : mregs[k][idx];
      end
      mcnt[k] = mcnt[k] + 32'd1;
    end
  endfunction

  // Entered just after a falling edge; stop_at > 0 ends the transfer early in
  // that access cycle, by dropping PSEL or by asserting PRESET.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input int stop_at,
                      input bit by_rst, output logic [31:0] rd);
    bit          eerr;
    logic [31:0] erd;
    int          n;
    psel = '0; psel[k] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    @(negedge clk);
    penable = 1'b1;
    n = 1;
    forever begin
      #1;
      if (n == stop_at) begin
        if (by_rst) begin
          rst = 1'b1;
          #1;
          chk("rst_pready", {31'd0, pready[k]}, 32'd0);
          model_reset();
        end else begin
          psel = '0; penable = 1'b0;
          #1;
          chk("abort_pready", {31'd0, pready[k]}, 32'd0);
        end
        psel = '0; penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd = '0;
        return;
      end
      if (pready[k]) break;
      if (n > 20) begin
        chk("timeout", {31'd0, pready[k]}, 32'd1);
        break;
      end
      @(negedge clk);
      n++;
    end
    model_xfer(k, wr, a, d, s, p, eerr, erd);
    chk("latency", 32'(n), 32'(ws(k) + 1));
    chk("pslverr", {31'd0, pslverr[k]}, {31'd0, eerr});
    chk("prdata", prdata[k], erd);
    rd = prdata[k];
    @(negedge clk);
    psel = '0; penable = 1'b0;
  endtask

  task automatic wr32(input int k, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    logic [31:0] rd;
    xfer(k, 1'b1, a, d, s, p, 0, 1'b0, rd);
  endtask

  task automatic rd32(input int k, input logic [31:0] a, input logic [3:0] s,
                      output logic [31:0] rd);
    xfer(k, 1'b0, a, '0, s, 3'b001, 0, 1'b0, rd);
  endtask

  initial begin
    logic [31:0] rd;
    bit          wr;
    int          k;
    int          stop;
    logic [3:0]  s;

    rst = 1'b1; psel = '0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; pprot = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_pready", {31'd0, pready[i]}, 32'd0);
      chk("rst_pslverr", {31'd0, pslverr[i]}, 32'd0);
      chk("rst_prdata", prdata[i], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Zero wait states: write/read
    wr32(0, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001);
    rd32(0, 32'h04, 4'h0, rd);
    chk("dead", rd, 32'hDEADBEEF);

    // Byte strobes
    wr32(0, 32'h08, 32'h11223344, 4'hF, 3'b001);
    wr32(0, 32'h08, 32'hAABBCCDD, 4'b0101, 3'b001);
    rd32(0, 32'h08, 4'h0, rd);
    chk("strb", rd, 32'h11BB33DD);

    // Error cases
    wr32(0, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b001);
    wr32(0, 32'h1C, 32'hFFFFFFFF, 4'hF, 3'b001);
    wr32(0, 32'h00, 32'h12345678, 4'hF, 3'b000);
    rd32(0, 32'h00, 4'h1, rd);
    rd32(0, 32'h00, 4'h0, rd);
    chk("noerrwr", rd, 32'h0);
    rd32(0, 32'h1C, 4'h0, rd);

    // PENABLE while idle is ignored
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0; pprot = 3'b001;
    #1;
    chk("idle_enable", {31'd0, pready[0]}, 32'd0);
    @(negedge clk);
    psel = '0; penable = 1'b0;
    rd32(0, 32'h00, 4'h0, rd);

    // Wait states and abort on the 3-wait instance, then a normal transfer
    wr32(2, 32'h0C, 32'hCAFEF00D, 4'hF, 3'b001);
    xfer(2, 1'b1, 32'h10, 32'h55555555, 4'hF, 3'b001, 2, 1'b0, rd);
    rd32(2, 32'h10, 4'h0, rd);
    chk("abort_nowr", rd, 32'h0);
    rd32(2, 32'h0C, 4'h0, rd);

    // Counter: 5 good + 2 errored transfers, then wrap
    for (int i = 0; i < 5; i++) wr32(1, 32'(i * 4), 32'(i + 1), 4'hF, 3'b001);
    wr32(1, 32'h20, 32'h1, 4'hF, 3'b001);
    wr32(1, 32'h00, 32'h1, 4'hF, 3'b000);
    rd32(1, 32'h1C, 4'h0, rd);
    chk("cnt5", rd, 32'd5);
    force g_dut[1].u_dut.r_xfer_cnt = 32'hFFFFFFFF;
    @(negedge clk);
    release g_dut[1].u_dut.r_xfer_cnt;
    mcnt[1] = 32'hFFFFFFFF;
    wr32(1, 32'h00, 32'h77, 4'hF, 3'b001);
    rd32(1, 32'h1C, 4'h0, rd);
    chk("cnt_wrap", rd, 32'h0);

    // Randomised traffic against the model
    for (int t = 0; t < 250; t++) begin
      k  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      s  = 4'($urandom);
      if (!wr && $urandom_range(0, 3) != 0) s = 4'h0;
      stop = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, ws(k) + 1)) : 0;
      xfer(k, wr, 32'($urandom_range(0, 39)), $urandom, s,
           ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom) | 3'b001, stop, 1'b0, rd);
    end

    // Async reset mid-transfer on the 2-wait instance, in its ready cycle
    wr32(1, 32'h04, 32'hA5A5A5A5, 4'hF, 3'b001);
    xfer(1, 1'b0, 32'h04, '0, 4'h0, 3'b001, 3, 1'b1, rd);
    for (int kk = 0; kk < 3; kk++) begin
      rd32(kk, 32'h1C, 4'h0, rd);
      chk("post_rst_cnt", rd, 32'h0);
      for (int i = 0; i < 7; i++) begin
        rd32(kk, 32'(i * 4), 4'h0, rd);
        chk("post_rst_reg", rd, 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
